// File: rtl/cordic_angle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_angle_sequencer: streams atan(2^-i) angle constants with handshake  |
// | and offers a registered random-access lookup port.  Rev 1.0                |
// +----------------------------------------------------------------------------+
module cordic_angle_sequencer #(
  parameter int WORD_LENGTH    = 16,
  parameter int ITERATIONS     = 14,
  parameter int ADDRESS_LENGTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      angle_valid,
  input  logic                      angle_ready,
  output logic [WORD_LENGTH-1:0]    angle,
  output logic [ADDRESS_LENGTH-1:0] index,
  output logic                      last,
  output logic                      done,
  input  logic                      lookup_en,
  input  logic [ADDRESS_LENGTH-1:0] lookup_addr,
  output logic [WORD_LENGTH-1:0]    lookup_data
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [ADDRESS_LENGTH-1:0] LAST_INDEX = ADDRESS_LENGTH'(ITERATIONS - 1);

  // floor(atan(2^-i) * 2^32 / (2*pi)); narrower words are truncations of these
  function automatic logic [31:0] t32(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:  v = 32'h2000_0000;
      5'd1:  v = 32'h12E4_051D;
      5'd2:  v = 32'h09FB_385B;
      5'd3:  v = 32'h0511_11D4;
      5'd4:  v = 32'h028B_0D43;
      5'd5:  v = 32'h0145_D7E1;
      5'd6:  v = 32'h00A2_F61E;
      5'd7:  v = 32'h0051_7C55;
      5'd8:  v = 32'h0028_BE53;
      5'd9:  v = 32'h0014_5F2E;
      5'd10: v = 32'h000A_2F98;
      5'd11: v = 32'h0005_17CC;
      5'd12: v = 32'h0002_8BE6;
      5'd13: v = 32'h0001_45F3;
      5'd14: v = 32'h0000_A2F9;
      5'd15: v = 32'h0000_517C;
      5'd16: v = 32'h0000_28BE;
      5'd17: v = 32'h0000_145F;
      5'd18: v = 32'h0000_0A2F;
      5'd19: v = 32'h0000_0517;
      5'd20: v = 32'h0000_028B;
      5'd21: v = 32'h0000_0145;
      5'd22: v = 32'h0000_00A2;
      5'd23: v = 32'h0000_0051;
      5'd24: v = 32'h0000_0028;
      5'd25: v = 32'h0000_0014;
      5'd26: v = 32'h0000_000A;
      5'd27: v = 32'h0000_0005;
      5'd28: v = 32'h0000_0002;
      5'd29: v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  function automatic logic [WORD_LENGTH-1:0] word(input logic [4:0] i);
    return WORD_LENGTH'(t32(i) >> (32 - WORD_LENGTH));
  endfunction

  state_t                      state_q, state_d;
  logic [ADDRESS_LENGTH-1:0]   index_q, index_d;
  logic [WORD_LENGTH-1:0]      angle_q, angle_d;
  logic                        last_q, last_d;
  logic                        done_q, done_d;
  logic [WORD_LENGTH-1:0]      lookup_data_q, lookup_data_d;
  logic [ADDRESS_LENGTH-1:0]   next_index;

  assign next_index = index_q + ADDRESS_LENGTH'(1);

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    angle_d       = angle_q;
    last_d        = last_q;
    done_d        = 1'b0;
    lookup_data_d = lookup_data_q;

    if (lookup_en) begin
      lookup_data_d = word(lookup_addr);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          index_d = '0;
          angle_d = word(5'd0);
          last_d  = (LAST_INDEX == '0);
        end
      end
      STREAM: begin
        // abort wins over a coincident transfer, even on the final beat
        if (abort) begin
          state_d = IDLE;
          index_d = '0;
          angle_d = '0;
          last_d  = 1'b0;
        end else if (angle_ready) begin
          if (last_q) begin
            state_d = IDLE;
            index_d = '0;
            angle_d = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = next_index;
            angle_d = word(next_index);
            last_d  = (next_index == LAST_INDEX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      index_q       <= '0;
      angle_q       <= '0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      lookup_data_q <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      angle_q       <= angle_d;
      last_q        <= last_d;
      done_q        <= done_d;
      lookup_data_q <= lookup_data_d;
    end
  end

  assign busy        = (state_q == STREAM);
  assign angle_valid = (state_q == STREAM);
  assign angle       = angle_q;
  assign index       = index_q;
  assign last        = last_q;
  assign done        = done_q;
  assign lookup_data = lookup_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_angle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cordic_angle_sequencer: self-checking bench, 16x14 and 24x20 instances  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cordic_angle_sequencer;

  localparam int W_A = 16, N_A = 14;
  localparam int W_B = 24, N_B = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 0, abort_a = 0, ready_a = 0, lk_en_a = 0;
  logic [4:0] lk_addr_a = 0;
  logic busy_a, valid_a, last_a, done_a;
  logic [W_A-1:0] angle_a, lk_data_a;
  logic [4:0] index_a;

  logic start_b = 0, abort_b = 0, ready_b = 0, lk_en_b = 0;
  logic [4:0] lk_addr_b = 0;
  logic busy_b, valid_b, last_b, done_b;
  logic [W_B-1:0] angle_b, lk_data_b;
  logic [4:0] index_b;

  cordic_angle_sequencer #(.WORD_LENGTH(W_A), .ITERATIONS(N_A), .ADDRESS_LENGTH(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .busy(busy_a),
    .angle_valid(valid_a), .angle_ready(ready_a), .angle(angle_a), .index(index_a),
    .last(last_a), .done(done_a), .lookup_en(lk_en_a), .lookup_addr(lk_addr_a),
    .lookup_data(lk_data_a));

  cordic_angle_sequencer #(.WORD_LENGTH(W_B), .ITERATIONS(N_B), .ADDRESS_LENGTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .busy(busy_b),
    .angle_valid(valid_b), .angle_ready(ready_b), .angle(angle_b), .index(index_b),
    .last(last_b), .done(done_b), .lookup_en(lk_en_b), .lookup_addr(lk_addr_b),
    .lookup_data(lk_data_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference table straight from the definition: floor(atan(2^-i) / (2*pi) * 2^32)
  function automatic logic [31:0] t32(input int i);
    real x, r;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    r = $atan(x) / (8.0 * $atan(1.0)) * 4294967296.0;
    return 32'($rtoi($floor(r)));
  endfunction

  function automatic logic [31:0] word(input int i, input int w);
    return t32(i) >> (32 - w);
  endfunction

  // Transaction-level model: is a sequence running, which beat is on offer
  bit ma_act, ma_done, mb_act, mb_done;
  int ma_idx, mb_idx;
  logic [31:0] ma_lk, mb_lk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_act <= 0; ma_idx <= 0; ma_done <= 0; ma_lk <= 0;
    end else begin
      ma_done <= 0;
      if (!ma_act) begin
        if (start_a) begin ma_act <= 1; ma_idx <= 0; end
      end else if (abort_a) begin
        ma_act <= 0; ma_idx <= 0;
      end else if (ready_a) begin
        if (ma_idx == N_A - 1) begin ma_act <= 0; ma_idx <= 0; ma_done <= 1; end
        else ma_idx <= ma_idx + 1;
      end
      if (lk_en_a) ma_lk <= word(int'(lk_addr_a), W_A);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_act <= 0; mb_idx <= 0; mb_done <= 0; mb_lk <= 0;
    end else begin
      mb_done <= 0;
      if (!mb_act) begin
        if (start_b) begin mb_act <= 1; mb_idx <= 0; end
      end else if (abort_b) begin
        mb_act <= 0; mb_idx <= 0;
      end else if (ready_b) begin
        if (mb_idx == N_B - 1) begin mb_act <= 0; mb_idx <= 0; mb_done <= 1; end
        else mb_idx <= mb_idx + 1;
      end
      if (lk_en_b) mb_lk <= word(int'(lk_addr_b), W_B);
    end
  end

  always @(negedge clk) begin
    check("a_busy",   busy_a,    ma_act);
    check("a_valid",  valid_a,   ma_act);
    check("a_angle",  angle_a,   ma_act ? word(ma_idx, W_A) : 32'h0);
    check("a_index",  index_a,   ma_idx);
    check("a_last",   last_a,    ma_act && ma_idx == N_A - 1);
    check("a_done",   done_a,    ma_done);
    check("a_lookup", lk_data_a, ma_lk);
    check("b_busy",   busy_b,    mb_act);
    check("b_valid",  valid_b,   mb_act);
    check("b_angle",  angle_b,   mb_act ? word(mb_idx, W_B) : 32'h0);
    check("b_index",  index_b,   mb_idx);
    check("b_last",   last_b,    mb_act && mb_idx == N_B - 1);
    check("b_done",   done_b,    mb_done);
    check("b_lookup", lk_data_b, mb_lk);
  end

  logic [31:0] qa[$], qb[$];
  int donecnt_a = 0, busycnt_a = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a && ready_a) qa.push_back(32'(angle_a));
      if (valid_b && ready_b) qb.push_back(32'(angle_b));
      if (done_a) donecnt_a++;
      if (busy_a) busycnt_a++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel 0: dut_a offering beat idx; 1: dut_a done; 2: dut_b done
  task automatic wait_for(input string name, input int sel, input int idx);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 80) begin
      case (sel)
        0: hit = valid_a && (int'(index_a) == idx);
        1: hit = done_a;
        default: hit = done_b;
      endcase
      if (!hit) begin step(); n++; end
    end
    check({name, "_timeout"}, 32'(n >= 80), 0);
  endtask

  logic [31:0] tmp;

  initial begin
    // reset state
    repeat (3) step();
    check("rst_busy", busy_a, 0);
    check("rst_angle", angle_a, 0);
    check("rst_lookup", lk_data_a, 0);
    rst_n = 1;
    repeat (3) step();
    check("idle_no_start", busy_a, 0);

    // full sequence at full throughput
    qa.delete(); donecnt_a = 0; busycnt_a = 0;
    ready_a = 1; start_a = 1;
    step(); start_a = 0;
    check("t2_beat0", angle_a, 32'h2000);
    check("t2_index0", index_a, 0);
    wait_for("t2_done", 1, 0);
    // start in the done cycle must be taken
    start_a = 1;
    step(); start_a = 0;
    check("t2_beats", qa.size(), 14);
    check("t2_b1", qa[1], 32'h12E4);
    check("t2_b2", qa[2], 32'h09FB);
    check("t2_b13", qa[13], 32'h0001);
    check("t2_done_pulses", donecnt_a, 1);
    check("t2_busy_cycles", busycnt_a, 14);
    check("done_cycle_start_busy", busy_a, 1);
    check("done_cycle_start_angle", angle_a, 32'h2000);
    qa.delete();

    // backpressure at index 2
    wait_for("t3_idx2", 0, 2);
    ready_a = 0;
    repeat (3) begin
      step();
      check("t3_hold_angle", angle_a, 32'h09FB);
      check("t3_hold_index", index_a, 2);
    end
    ready_a = 1;
    step();
    check("t3_resume_index", index_a, 3);
    check("t3_resume_angle", angle_a, 32'h0511);
    wait_for("t3_done", 1, 0);
    step();
    check("t3_beats", qa.size(), 14);
    check("t3_b3", qa[3], 32'h0511);

    // ignored start, abort mid-stream, abort on final beat
    qa.delete(); donecnt_a = 0;
    start_a = 1; step(); start_a = 0;
    wait_for("t4_idx4", 0, 4);
    start_a = 1; step(); start_a = 0;
    check("t4_start_ignored", index_a, 5);
    abort_a = 1; step(); abort_a = 0;
    check("t4_abort_valid", valid_a, 0);
    check("t4_abort_index", index_a, 0);
    step();
    check("t4_abort_no_done", done_a, 0);
    start_a = 1; step(); start_a = 0;
    check("t4_restart_angle", angle_a, 32'h2000);
    wait_for("t4_idx13", 0, 13);
    check("t4_last_flag", last_a, 1);
    abort_a = 1; step(); abort_a = 0;
    check("t4_last_abort_busy", busy_a, 0);
    check("t4_last_abort_done", done_a, 0);
    step();
    check("t4_done_pulses", donecnt_a, 0);

    // lookup port during a stream
    qa.delete();
    start_a = 1; step(); start_a = 0;
    lk_en_a = 1; lk_addr_a = 5'd3; step();
    check("t6_lk3", lk_data_a, 32'h0511);
    lk_addr_a = 5'd15; step();
    check("t6_lk15", lk_data_a, 32'h0000);
    lk_addr_a = 5'd1; step();
    check("t6_lk1", lk_data_a, 32'h12E4);
    lk_en_a = 0; lk_addr_a = 5'd7; step(); step();
    check("t6_lk_hold", lk_data_a, 32'h12E4);
    wait_for("t6_done", 1, 0);
    step();
    check("t6_beats", qa.size(), 14);

    // asynchronous reset in the middle of a sequence
    start_a = 1; step(); start_a = 0;
    lk_en_a = 1; lk_addr_a = 5'd2; step(); lk_en_a = 0;
    wait_for("t1_idx6", 0, 6);
    #2 rst_n = 0;
    #1;
    check("t1_rst_busy", busy_a, 0);
    check("t1_rst_valid", valid_a, 0);
    check("t1_rst_angle", angle_a, 0);
    check("t1_rst_index", index_a, 0);
    check("t1_rst_last", last_a, 0);
    check("t1_rst_done", done_a, 0);
    check("t1_rst_lookup", lk_data_a, 0);
    step(); rst_n = 1;
    repeat (4) step();
    check("t1_post_idle", busy_a, 0);

    // wide instance
    qb.delete();
    ready_b = 1; start_b = 1; step(); start_b = 0;
    wait_for("t5_done", 2, 0);
    step();
    check("t5_beats", qb.size(), 20);
    check("t5_b0", qb[0], 32'h200000);
    check("t5_b1", qb[1], 32'h12E405);
    tmp = qb[1];
    check("t5_b1_hi", tmp[23:8], 32'h12E4);
    tmp = qb[13];
    check("t5_b13_hi", tmp[23:8], 32'h0001);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
